seq_normalizer32: RTL and testbench



---
 rtl/seq_normalizer32_pkg.sv | 24 ++
 rtl/seq_normalizer32_if.sv | 16 +
 rtl/seq_normalizer32_zero_detect.sv | 13 +
 rtl/seq_normalizer32.sv | 91 +++++++++
 tb/tb_seq_normalizer32.sv | 126 ++++++++++++
 5 files changed

// File: rtl/seq_normalizer32_pkg.sv
// rtl/seq_normalizer32_pkg.sv - shared widths, state encoding and edge-field mask helper
package seq_normalizer32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 5;
    localparam int K_WIDTH    = 3;

    typedef enum logic [1:0] {
        NORM_IDLE  = 2'b00,
        NORM_SHIFT = 2'b01,
        NORM_DONE  = 2'b10
    } norm_state_e;

    // Bits that a stage of width 2^k would shift out: top bits for left, bottom bits for right.
    function automatic logic [DATA_WIDTH-1:0] edge_mask(input logic [K_WIDTH-1:0] k,
                                                        input logic lnr);
        logic [DATA_WIDTH-1:0] ones;
        logic [5:0]            amt;
        ones = '1;
        amt  = 6'd1 << k;
        return lnr ? ~(ones >> amt) : ~(ones << amt);
    endfunction

endpackage

// File: rtl/seq_normalizer32_if.sv
// rtl/seq_normalizer32_if.sv - request/result bundle between requester and normalizer
interface seq_normalizer32_if;
    import seq_normalizer32_pkg::*;

    logic                  START;
    logic                  LnR;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Y;
    logic [CNT_WIDTH-1:0]  CNT;
    logic                  ZERO;
    logic                  BUSY;
    logic                  DONE;

    modport master (output START, LnR, D, input Y, CNT, ZERO, BUSY, DONE);
    modport slave  (input START, LnR, D, output Y, CNT, ZERO, BUSY, DONE);
endinterface

// File: rtl/seq_normalizer32_zero_detect.sv
// rtl/seq_normalizer32_zero_detect.sv - flags an all-zero 2^k-bit edge field of the work word
module seq_normalizer32_zero_detect
    import seq_normalizer32_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] w_i,
    input  logic [K_WIDTH-1:0]    k_i,
    input  logic                  lnr_i,
    output logic                  field_zero_o
);

    assign field_zero_o = ((w_i & edge_mask(k_i, lnr_i)) == '0);

endmodule

// File: rtl/seq_normalizer32.sv
// rtl/seq_normalizer32.sv - five-stage binary-search normalizer returning normalized word and CLZ/CTZ
module seq_normalizer32
    import seq_normalizer32_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    seq_normalizer32_if.slave  bus
);

    norm_state_e           state_q;
    logic [DATA_WIDTH-1:0] w_q, w_d, w_shift;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [K_WIDTH-1:0]    k_q;
    logic                  mode_q;
    logic                  dzero_q;
    logic [DATA_WIDTH-1:0] y_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  zero_q, busy_q, done_q;
    logic [5:0]            amt;
    logic                  field_zero;

    seq_normalizer32_zero_detect u_zero_detect (
        .w_i          (w_q),
        .k_i          (k_q),
        .lnr_i        (mode_q),
        .field_zero_o (field_zero)
    );

    always_comb begin
        amt     = 6'd1 << k_q;
        w_shift = mode_q ? (w_q << amt) : (w_q >> amt);
        w_d     = field_zero ? w_shift : w_q;
        acc_d   = acc_q | (field_zero ? (5'd1 << k_q) : 5'd0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= NORM_IDLE;
            w_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            dzero_q <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                NORM_IDLE: begin
                    if (bus.START) begin
                        w_q     <= bus.D;
                        mode_q  <= bus.LnR;
                        dzero_q <= (bus.D == '0);
                        acc_q   <= '0;
                        k_q     <= 3'd4;
                        busy_q  <= 1'b1;
                        state_q <= NORM_SHIFT;
                    end
                end
                NORM_SHIFT: begin
                    w_q   <= w_d;
                    acc_q <= acc_d;
                    k_q   <= k_q - 3'd1;
                    if (k_q == 3'd0) begin
                        // A zero operand would naturally report 31; report 0 instead.
                        y_q     <= dzero_q ? '0 : w_d;
                        cnt_q   <= dzero_q ? '0 : acc_d;
                        zero_q  <= dzero_q;
                        done_q  <= 1'b1;
                        state_q <= NORM_DONE;
                    end
                end
                NORM_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= NORM_IDLE;
                end
                default: state_q <= NORM_IDLE;
            endcase
        end
    end

    assign bus.Y    = y_q;
    assign bus.CNT  = cnt_q;
    assign bus.ZERO = zero_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_seq_normalizer32.sv
// tb/tb_seq_normalizer32.sv - directed self-checking bench for seq_normalizer32
module tb_seq_normalizer32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_seen;

    seq_normalizer32_if bus ();

    seq_normalizer32 dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pulse START for one edge (E0), scramble inputs while busy, and check the fixed 5-edge latency.
    task automatic do_op(input string tag, input logic [31:0] d, input logic lnr,
                         input logic [31:0] exp_y, input logic [4:0] exp_cnt, input logic exp_zero);
        @(negedge clk);
        bus.START = 1'b1; bus.D = d; bus.LnR = lnr;
        @(negedge clk);
        bus.START = 1'b0; bus.D = 32'hDEAD_BEEF; bus.LnR = ~lnr;
        check({tag, " busy_e0"}, {31'd0, bus.BUSY}, 32'd1);
        repeat (4) @(negedge clk);
        check({tag, " done_e4"}, {31'd0, bus.DONE}, 32'd0);
        @(negedge clk);
        check({tag, " done_e5"}, {31'd0, bus.DONE}, 32'd1);
        check({tag, " y"},       bus.Y, exp_y);
        check({tag, " cnt"},     {27'd0, bus.CNT}, {27'd0, exp_cnt});
        check({tag, " zero"},    {31'd0, bus.ZERO}, {31'd0, exp_zero});
        @(negedge clk);
        check({tag, " done_e6"}, {31'd0, bus.DONE}, 32'd0);
        check({tag, " busy_e6"}, {31'd0, bus.BUSY}, 32'd0);
        check({tag, " y_hold"},  bus.Y, exp_y);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n     = 1'b0;
        bus.START = 1'b0;
        bus.LnR   = 1'b0;
        bus.D     = 32'h0;
        repeat (2) @(negedge clk);
        check("rst y",    bus.Y, 32'h0);
        check("rst cnt",  {27'd0, bus.CNT}, 32'd0);
        check("rst zero", {31'd0, bus.ZERO}, 32'd0);
        check("rst busy", {31'd0, bus.BUSY}, 32'd0);
        check("rst done", {31'd0, bus.DONE}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("clz1",     32'h0000_0001, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
        do_op("clz_mid",  32'h0001_2340, 1'b1, 32'h91A0_0000, 5'd15, 1'b0);
        do_op("ctz_mid",  32'h0001_2340, 1'b0, 32'h0000_048D, 5'd6,  1'b0);
        do_op("zero_l",   32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1);
        do_op("clz_top",  32'h8000_0000, 1'b1, 32'h8000_0000, 5'd0,  1'b0);
        do_op("zero_r",   32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1);
        do_op("ctz_bot",  32'h0000_0001, 1'b0, 32'h0000_0001, 5'd0,  1'b0);
        do_op("ctz_top",  32'h8000_0000, 1'b0, 32'h0000_0001, 5'd31, 1'b0);
        do_op("clz_ff",   32'h0F00_0000, 1'b1, 32'hF000_0000, 5'd4,  1'b0);

        // Second START during SHIFT must be ignored.
        done_seen = 0;
        @(negedge clk);
        bus.START = 1'b1; bus.D = 32'h8000_0000; bus.LnR = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        @(negedge clk);
        bus.START = 1'b1; bus.D = 32'h0000_0001;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.DONE) done_seen++;
        end
        check("busy_start y",   bus.Y, 32'h8000_0000);
        check("busy_start cnt", {27'd0, bus.CNT}, 32'd0);
        @(negedge clk);
        check("busy_start busy_e6", {31'd0, bus.BUSY}, 32'd0);
        repeat (8) begin
            if (bus.DONE) done_seen++;
            @(negedge clk);
        end
        check("busy_start done_count", done_seen, 32'd1);

        // Reset in the middle of an operation abandons it.
        @(negedge clk);
        bus.START = 1'b1; bus.D = 32'h0000_0001; bus.LnR = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst y",    bus.Y, 32'h0);
        check("midrst cnt",  {27'd0, bus.CNT}, 32'd0);
        check("midrst busy", {31'd0, bus.BUSY}, 32'd0);
        check("midrst done", {31'd0, bus.DONE}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.DONE) done_seen++;
        end
        check("midrst no_done", done_seen, 32'd0);
        do_op("after_rst", 32'h00FF_0000, 1'b0, 32'h0000_00FF, 5'd16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
